// File: rtl/mac_l2_seq.sv
// Layer-2 sequencer: streams N_IN activations into the MAC array, then scans the
// N_OUT accumulators for the arg-max class. Single FSM with registered strobes.
`timescale 1ns/1ps
module mac_l2_seq #(
    parameter  int N_IN  = 32,
    parameter  int N_OUT = 10,
    parameter  int ACT_W = 8,
    parameter  int ACC_W = 20,
    localparam int AW    = $clog2(N_IN),
    localparam int CW    = $clog2(N_OUT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic [AW-1:0]                     act_addr,
    input  logic signed [ACT_W-1:0]           act_data,
    output logic [AW-1:0]                     w_row,
    output logic                              mac_clr,
    output logic                              mac_init_bias,
    output logic                              mac_en,
    output logic signed [ACT_W-1:0]           mac_activation,
    input  logic [N_OUT-1:0][ACC_W-1:0]       acc_in,
    output logic                              busy,
    output logic                              done,
    output logic [CW-1:0]                     class_out,
    output logic signed [ACC_W-1:0]           max_val
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_BIAS, S_RUN, S_WAIT, S_ARGMAX, S_DONE
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           act_addr_q;
    logic [AW-1:0]           run_cnt_q;
    logic [CW-1:0]           k_q;
    logic [CW-1:0]           idx_q;
    logic signed [ACC_W-1:0] max_q;
    logic [CW-1:0]           class_q;
    logic signed [ACC_W-1:0] max_val_q;
    logic                    mac_clr_q;
    logic                    mac_bias_q;
    logic                    mac_en_q;
    logic                    busy_q;
    logic                    done_q;

    // Running-max candidate for the current scan index; strict '>' keeps the
    // lowest index on ties, k==0 loads unconditionally.
    logic signed [ACC_W-1:0] cand;
    logic                    upd;
    logic signed [ACC_W-1:0] max_d;
    logic [CW-1:0]           idx_d;

    always_comb begin
        cand  = $signed(acc_in[k_q]);
        upd   = (k_q == '0) || (cand > max_q);
        max_d = upd ? cand : max_q;
        idx_d = upd ? k_q : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            act_addr_q <= '0;
            run_cnt_q  <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            max_q      <= '0;
            class_q    <= '0;
            max_val_q  <= '0;
            mac_clr_q  <= 1'b0;
            mac_bias_q <= 1'b0;
            mac_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mac_clr_q  <= 1'b0;
            mac_bias_q <= 1'b0;
            mac_en_q   <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CLR;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLR: begin
                    state_q    <= S_BIAS;
                    mac_bias_q <= 1'b1;
                    act_addr_q <= '0;
                end
                S_BIAS: begin
                    // Address 0 was issued during BIAS, so RUN cycle 0 sees its data.
                    state_q    <= S_RUN;
                    mac_en_q   <= 1'b1;
                    run_cnt_q  <= '0;
                    act_addr_q <= (N_IN == 1) ? '0 : AW'(1);
                end
                S_RUN: begin
                    if (run_cnt_q == AW'(N_IN - 1)) begin
                        state_q    <= S_WAIT;
                        run_cnt_q  <= '0;
                        act_addr_q <= '0;
                    end else begin
                        mac_en_q   <= 1'b1;
                        run_cnt_q  <= run_cnt_q + AW'(1);
                        act_addr_q <= (act_addr_q == AW'(N_IN - 1)) ? '0
                                                                    : act_addr_q + AW'(1);
                    end
                end
                S_WAIT: begin
                    state_q <= S_ARGMAX;
                    k_q     <= '0;
                end
                S_ARGMAX: begin
                    max_q <= max_d;
                    idx_q <= idx_d;
                    if (k_q == CW'(N_OUT - 1)) begin
                        state_q   <= S_DONE;
                        class_q   <= idx_d;
                        max_val_q <= max_d;
                        done_q    <= 1'b1;
                        k_q       <= '0;
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign act_addr       = act_addr_q;
    assign w_row          = act_addr_q;
    assign mac_clr        = mac_clr_q;
    assign mac_init_bias  = mac_bias_q;
    assign mac_en         = mac_en_q;
    assign mac_activation = act_data;
    assign busy           = busy_q;
    assign done           = done_q;
    assign class_out      = class_q;
    assign max_val        = max_val_q;

endmodule
